writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 SHALL have parameter INSTRET_WIDTH, default 64, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port exwb_alu_axis_if  axis_if.s  $bits(exwb_tdata_t)  results from the ALU execution unit.
REQ-005 SHALL have port exwb_lsu_axis_if  axis_if.s  $bits(exwb_tdata_t)  results from the load/store unit.
REQ-006 SHALL have port wbrf_axis_if  axis_if.m  $bits(wbrf_tdata_t)  writeback to the register file.
REQ-007 SHALL have port invalidate  input  1  pipeline flush request.
REQ-008 SHALL have port instret  output  INSTRET_WIDTH  count of completed writeback transfers.

Function
REQ-009 SHALL hold the output in one registered stage: out_valid and out_data flops drive wbrf tvalid/tdata directly, with no combinational path from inputs.
REQ-010 SHALL treat the output stage as loadable in a cycle when out_valid=0 or wbrf tready=1, and invalidate=0.
REQ-011 SHALL grant at most one source per cycle, and only when the output stage is loadable.
REQ-012 SHALL grant the only valid source when exactly one of ALU/LSU tvalid is 1.
REQ-013 SHALL, when both sources are valid, grant the source not granted last (round-robin via a 1-bit last_grant flop, updated only on an accepted transfer).
REQ-014 SHALL drive source tready=1 only for the granted source; the other source's tready SHALL be 0.
REQ-015 SHALL never combinationally depend a source's tready on that same source's tvalid except through grant selection; tvalid of a waiting source SHALL be held by the source (AXIS rule).
REQ-016 SHALL, on an accepted input, load out_data.ex_data with the source tdata and out_data.wdata with the source tdata result field, and set out_valid=1 next cycle.
REQ-017 SHALL clear out_valid next cycle when out_valid=1, tready=1 and no input is accepted (1-cycle latency input-to-output, full throughput with back-to-back inputs).
REQ-018 SHALL hold out_valid and out_data unchanged while out_valid=1 and tready=0.
REQ-019 SHALL pass rd=0 results through unchanged; suppression of x0 writes belongs to the register file.
REQ-020 SHALL increment instret by 1 on every cycle with wbrf tvalid=1 and tready=1, wrapping modulo 2^INSTRET_WIDTH.
REQ-021 SHALL, with invalidate=1, drive both source treadys to 0 and clear out_valid next cycle.
REQ-022 SHALL let a wbrf transfer already presented in the invalidate cycle complete (tvalid not masked) and count it in instret.
REQ-023 SHALL leave last_grant unchanged in an invalidate cycle.
REQ-024 SHALL give reset priority over invalidate and all handshakes.

Reset
REQ-025 SHALL, while rst=1 at posedge clk, set out_valid=0, instret=0, last_grant=LSU (ALU wins the first tie).
REQ-026 SHALL drive both source treadys to 0 while rst=1.
REQ-027 SHALL not reset out_data; its value is don't-care while out_valid=0.
REQ-028 SHALL, on reset mid-transfer, drop any pending output without incrementing instret.

Verification
REQ-029 SHALL cover: ALU-only stream, result 0x1234 to rd=5, tready=1 -> wbrf tvalid one cycle later, wdata=0x1234, rd=5, instret=1.
REQ-030 SHALL cover: ALU and LSU valid together for 4 cycles after reset -> grants ALU, LSU, ALU, LSU; instret=4 after the last transfer drains.
REQ-031 SHALL cover: wbrf tready held 0 for 3 cycles with output valid -> tdata stable, both source treadys 0, instret unchanged; all pending data delivered in order after release.
REQ-032 SHALL cover: invalidate pulsed while out_valid=1, tready=1, ALU valid -> current transfer completes (instret+1), ALU not accepted, out_valid=0 next cycle.
REQ-033 SHALL cover: rst asserted with out_valid=1 and instret=7 -> next cycle out_valid=0, instret=0, next tie grants ALU.
REQ-034 SHALL cover: instret preloaded to all-ones by forcing INSTRET_WIDTH=4 and 15 transfers, then one more -> instret=0.

Source files
------------

// File: rtl/writeback_if.sv
// Shared payload types for the execute->writeback->register-file path, and the
// generic AXI-Stream style handshake bundle used on every writeback port.

package writeback_pkg;

   // Result handed over by an execution unit (ALU or LSU).
   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] result;
   } exwb_tdata_t;

   // Register-file write: the full execute record plus the value to write.
   typedef struct packed {
      exwb_tdata_t ex_data;
      logic [31:0] wdata;
   } wbrf_tdata_t;

endpackage

interface axis_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;

   modport m (output tvalid, output tdata, input tready);
   modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/writeback.sv
// Writeback stage: round-robin merge of ALU and LSU results into one
// registered output slot that feeds the register file, with a flush input
// and a retired-instruction counter.

module writeback
   import writeback_pkg::*;
#(
   parameter int INSTRET_WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   axis_if.s                        exwb_alu_axis_if,
   axis_if.s                        exwb_lsu_axis_if,
   axis_if.m                        wbrf_axis_if,
   input  logic                     invalidate,
   output logic [INSTRET_WIDTH-1:0] instret
);

   localparam int   NUM_SRC = 2;
   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_LSU = 1'b1;

   logic                     out_valid_reg;
   wbrf_tdata_t              out_data_reg;
   logic                     last_grant_reg;
   logic [INSTRET_WIDTH-1:0] instret_reg;

   logic [NUM_SRC-1:0]       src_valid;
   exwb_tdata_t              src_data [NUM_SRC];
   logic [NUM_SRC-1:0]       grant;
   logic                     loadable;
   logic                     grant_any;
   logic                     grant_src;
   logic                     out_xfer;
   exwb_tdata_t              sel_data;

   assign src_valid[SRC_ALU] = exwb_alu_axis_if.tvalid;
   assign src_valid[SRC_LSU] = exwb_lsu_axis_if.tvalid;
   assign src_data[SRC_ALU]  = exwb_alu_axis_if.tdata;
   assign src_data[SRC_LSU]  = exwb_lsu_axis_if.tdata;

   // The slot can take a new result when it is empty or draining this cycle;
   // a flush or reset blocks every source.
   assign loadable = (!out_valid_reg || wbrf_axis_if.tready) && !invalidate && !rst;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_grant
         // A lone valid source wins; on a tie, the source that did not win last time wins.
         assign grant[gi] = loadable && src_valid[gi] &&
                            (!src_valid[NUM_SRC-1-gi] || (int'(last_grant_reg) != gi));
      end
   endgenerate

   assign grant_any = |grant;
   assign grant_src = grant[SRC_LSU];
   assign sel_data  = src_data[grant_src];
   assign out_xfer  = out_valid_reg && wbrf_axis_if.tready;

   assign exwb_alu_axis_if.tready = grant[SRC_ALU];
   assign exwb_lsu_axis_if.tready = grant[SRC_LSU];

   assign wbrf_axis_if.tvalid = out_valid_reg;
   assign wbrf_axis_if.tdata  = out_data_reg;
   assign instret             = instret_reg;

   // Control state: slot occupancy, round-robin pointer and retired count.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg  <= 1'b0;
         last_grant_reg <= SRC_LSU;
         instret_reg    <= '0;
      end else begin
         // A transfer already on the output completes even during a flush.
         if (out_xfer) begin
            instret_reg <= instret_reg + INSTRET_WIDTH'(1);
         end
         if (invalidate) begin
            out_valid_reg <= 1'b0;
         end else if (grant_any) begin
            out_valid_reg  <= 1'b1;
            last_grant_reg <= grant_src;
         end else if (wbrf_axis_if.tready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   // Output payload; only meaningful while out_valid_reg is set, so it has no reset.
   always_ff @(posedge clk) begin
      if (grant_any) begin
         out_data_reg.ex_data <= sel_data;
         out_data_reg.wdata   <= sel_data.result;
      end
   end

endmodule

// File: tb/tb_writeback.sv
// Bench for the writeback stage: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model of the arbitration rules.

module tb_writeback;
   import writeback_pkg::*;

   localparam int IW  = 4;
   localparam int EXW = $bits(exwb_tdata_t);
   localparam int WBW = $bits(wbrf_tdata_t);

   logic          clk;
   logic          rst;
   logic          invalidate;
   logic [IW-1:0] instret;
   wbrf_tdata_t   wb_data;
   int            total;
   int            bad;

   axis_if #(.DATA_WIDTH(EXW)) alu_if ();
   axis_if #(.DATA_WIDTH(EXW)) lsu_if ();
   axis_if #(.DATA_WIDTH(WBW)) wb_if ();

   assign wb_data = wb_if.tdata;

   writeback #(.INSTRET_WIDTH(IW)) dut (
      .clk              (clk),
      .rst              (rst),
      .exwb_alu_axis_if (alu_if),
      .exwb_lsu_axis_if (lsu_if),
      .wbrf_axis_if     (wb_if),
      .invalidate       (invalidate),
      .instret          (instret)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   function automatic exwb_tdata_t mk(input logic [4:0] rd, input logic [31:0] res);
      exwb_tdata_t e;
      e.pc     = $urandom;
      e.rd     = rd;
      e.result = res;
      return e;
   endfunction

   // Expected register-file record for a given execute result.
   function automatic wbrf_tdata_t wb_of(input exwb_tdata_t e);
      wbrf_tdata_t w;
      w.ex_data = e;
      w.wdata   = e.result;
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst           = 1'b1;
      invalidate    = 1'b0;
      alu_if.tvalid = 1'b0;
      lsu_if.tvalid = 1'b0;
      alu_if.tdata  = '0;
      lsu_if.tdata  = '0;
      wb_if.tready  = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      invalidate    = 1'b1;
      alu_if.tvalid = 1'b1;
      lsu_if.tvalid = 1'b1;
      alu_if.tdata  = '0;
      lsu_if.tdata  = '0;
      wb_if.tready  = 1'b1;
      step();
      @(negedge clk);
      total++;
      if (alu_if.tready !== 1'b0) begin bad++; $display("FAIL rst_alu_tready: got %b want 0", alu_if.tready); end
      total++;
      if (lsu_if.tready !== 1'b0) begin bad++; $display("FAIL rst_lsu_tready: got %b want 0", lsu_if.tready); end
      total++;
      if (wb_if.tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b want 0", wb_if.tvalid); end
      total++;
      if (instret !== '0) begin bad++; $display("FAIL rst_instret: got %0d want 0", instret); end
      step();
      rst           = 1'b0;
      invalidate    = 1'b0;
      alu_if.tvalid = 1'b0;
      lsu_if.tvalid = 1'b0;
      @(negedge clk);
      total++;
      if (wb_if.tvalid !== 1'b0) begin bad++; $display("FAIL post_rst_tvalid: got %b want 0", wb_if.tvalid); end
      step();
   endtask

   task automatic test_alu_single();
      exwb_tdata_t x;
      apply_reset();
      wb_if.tready  = 1'b1;
      x             = mk(5'd5, 32'h1234);
      alu_if.tvalid = 1'b1;
      alu_if.tdata  = x;
      @(negedge clk);
      total++;
      if (alu_if.tready !== 1'b1) begin bad++; $display("FAIL single_alu_tready: got %b want 1", alu_if.tready); end
      step();
      alu_if.tvalid = 1'b0;
      @(negedge clk);
      total++;
      if (wb_if.tvalid !== 1'b1) begin bad++; $display("FAIL single_tvalid: got %b want 1", wb_if.tvalid); end
      total++;
      if (wb_data.wdata !== 32'h1234) begin bad++; $display("FAIL single_wdata: got %h want 00001234", wb_data.wdata); end
      total++;
      if (wb_data.ex_data.rd !== 5'd5) begin bad++; $display("FAIL single_rd: got %0d want 5", wb_data.ex_data.rd); end
      total++;
      if (wb_data !== wb_of(x)) begin bad++; $display("FAIL single_tdata: got %h want %h", wb_data, wb_of(x)); end
      step();
      @(negedge clk);
      total++;
      if (instret !== IW'(1)) begin bad++; $display("FAIL single_instret: got %0d want 1", instret); end
      total++;
      if (wb_if.tvalid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", wb_if.tvalid); end
      step();
   endtask

   task automatic test_tie_round_robin();
      exwb_tdata_t a [4];
      exwb_tdata_t l [4];
      exwb_tdata_t exp_seq [4];
      int ai;
      int li;
      apply_reset();
      wb_if.tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a[i] = mk(5'(i + 1), $urandom);
         l[i] = mk(5'(i + 9), $urandom);
      end
      // Strict alternation starting with the ALU after reset.
      exp_seq[0] = a[0];
      exp_seq[1] = l[0];
      exp_seq[2] = a[1];
      exp_seq[3] = l[1];
      ai = 0;
      li = 0;
      for (int i = 0; i < 4; i++) begin
         alu_if.tvalid = 1'b1;
         alu_if.tdata  = a[ai];
         lsu_if.tvalid = 1'b1;
         lsu_if.tdata  = l[li];
         @(negedge clk);
         total++;
         if (alu_if.tready !== (i % 2 == 0)) begin bad++; $display("FAIL tie_alu_grant%0d: got %b want %b", i, alu_if.tready, (i % 2 == 0)); end
         total++;
         if (lsu_if.tready !== (i % 2 == 1)) begin bad++; $display("FAIL tie_lsu_grant%0d: got %b want %b", i, lsu_if.tready, (i % 2 == 1)); end
         if (i > 0) begin
            total++;
            if (wb_data !== wb_of(exp_seq[i-1])) begin bad++; $display("FAIL tie_data%0d: got %h want %h", i - 1, wb_data, wb_of(exp_seq[i-1])); end
         end
         if (alu_if.tready === 1'b1 && ai < 3) ai++;
         if (lsu_if.tready === 1'b1 && li < 3) li++;
         step();
      end
      alu_if.tvalid = 1'b0;
      lsu_if.tvalid = 1'b0;
      @(negedge clk);
      total++;
      if (wb_data !== wb_of(exp_seq[3])) begin bad++; $display("FAIL tie_data3: got %h want %h", wb_data, wb_of(exp_seq[3])); end
      step();
      @(negedge clk);
      total++;
      if (instret !== IW'(4)) begin bad++; $display("FAIL tie_instret: got %0d want 4", instret); end
      step();
   endtask

   task automatic test_backpressure();
      exwb_tdata_t x0;
      exwb_tdata_t x1;
      exwb_tdata_t y0;
      apply_reset();
      x0 = mk(5'd3, $urandom);
      x1 = mk(5'd4, $urandom);
      y0 = mk(5'd6, $urandom);
      wb_if.tready  = 1'b1;
      alu_if.tvalid = 1'b1;
      alu_if.tdata  = x0;
      step();
      wb_if.tready  = 1'b0;
      alu_if.tdata  = x1;
      lsu_if.tvalid = 1'b1;
      lsu_if.tdata  = y0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (wb_data !== wb_of(x0) || wb_if.tvalid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d: got %b/%h want 1/%h", k, wb_if.tvalid, wb_data, wb_of(x0)); end
         total++;
         if ({alu_if.tready, lsu_if.tready} !== 2'b00) begin bad++; $display("FAIL bp_treadys%0d: got %b want 00", k, {alu_if.tready, lsu_if.tready}); end
         total++;
         if (instret !== '0) begin bad++; $display("FAIL bp_instret%0d: got %0d want 0", k, instret); end
         step();
      end
      // ALU took the last transfer, so the pending tie goes to the LSU first.
      wb_if.tready = 1'b1;
      @(negedge clk);
      total++;
      if ({alu_if.tready, lsu_if.tready} !== 2'b01) begin bad++; $display("FAIL bp_release_grant: got %b want 01", {alu_if.tready, lsu_if.tready}); end
      step();
      lsu_if.tvalid = 1'b0;
      @(negedge clk);
      total++;
      if (wb_data !== wb_of(y0)) begin bad++; $display("FAIL bp_order1: got %h want %h", wb_data, wb_of(y0)); end
      total++;
      if (alu_if.tready !== 1'b1) begin bad++; $display("FAIL bp_alu_after: got %b want 1", alu_if.tready); end
      step();
      alu_if.tvalid = 1'b0;
      @(negedge clk);
      total++;
      if (wb_data !== wb_of(x1) || wb_if.tvalid !== 1'b1) begin bad++; $display("FAIL bp_order2: got %b/%h want 1/%h", wb_if.tvalid, wb_data, wb_of(x1)); end
      step();
      @(negedge clk);
      total++;
      if (instret !== IW'(3)) begin bad++; $display("FAIL bp_instret_end: got %0d want 3", instret); end
      step();
   endtask

   task automatic test_invalidate();
      apply_reset();
      wb_if.tready  = 1'b1;
      alu_if.tvalid = 1'b1;
      alu_if.tdata  = mk(5'd7, $urandom);
      step();
      alu_if.tdata = mk(5'd8, $urandom);
      invalidate   = 1'b1;
      @(negedge clk);
      total++;
      if (alu_if.tready !== 1'b0) begin bad++; $display("FAIL inv_alu_tready: got %b want 0", alu_if.tready); end
      total++;
      if (wb_if.tvalid !== 1'b1) begin bad++; $display("FAIL inv_tvalid_kept: got %b want 1", wb_if.tvalid); end
      step();
      invalidate    = 1'b0;
      alu_if.tvalid = 1'b0;
      @(negedge clk);
      total++;
      if (wb_if.tvalid !== 1'b0) begin bad++; $display("FAIL inv_cleared: got %b want 0", wb_if.tvalid); end
      total++;
      if (instret !== IW'(1)) begin bad++; $display("FAIL inv_instret: got %0d want 1", instret); end
      step();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      wb_if.tready  = 1'b1;
      alu_if.tvalid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         alu_if.tdata = mk(5'(i), $urandom);
         step();
      end
      alu_if.tvalid = 1'b0;
      rst           = 1'b1;
      @(negedge clk);
      total++;
      if (instret !== IW'(7) || wb_if.tvalid !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got %0d/%b want 7/1", instret, wb_if.tvalid); end
      step();
      rst           = 1'b0;
      alu_if.tvalid = 1'b1;
      lsu_if.tvalid = 1'b1;
      @(negedge clk);
      total++;
      if (wb_if.tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid: got %b want 0", wb_if.tvalid); end
      total++;
      if (instret !== '0) begin bad++; $display("FAIL rstmid_instret: got %0d want 0", instret); end
      total++;
      if ({alu_if.tready, lsu_if.tready} !== 2'b10) begin bad++; $display("FAIL rstmid_tie: got %b want 10", {alu_if.tready, lsu_if.tready}); end
      step();
      alu_if.tvalid = 1'b0;
      lsu_if.tvalid = 1'b0;
      step();
   endtask

   task automatic test_instret_wrap();
      apply_reset();
      wb_if.tready  = 1'b1;
      lsu_if.tvalid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         lsu_if.tdata = mk(5'(i), $urandom);
         step();
      end
      lsu_if.tvalid = 1'b0;
      @(negedge clk);
      total++;
      if (instret !== {IW{1'b1}}) begin bad++; $display("FAIL wrap_all_ones: got %0d want 15", instret); end
      step();
      @(negedge clk);
      total++;
      if (instret !== '0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", instret); end
      step();
   endtask

   task automatic test_random();
      exwb_tdata_t   a_item;
      exwb_tdata_t   l_item;
      logic          a_v;
      logic          l_v;
      logic          a_take;
      logic          l_take;
      logic          m_full;
      wbrf_tdata_t   m_data;
      logic          m_prev_lsu;
      logic [IW-1:0] m_cnt;
      logic          rdy;
      logic          inv;
      logic          open_slot;
      logic          exp_a;
      logic          exp_l;
      apply_reset();
      a_item     = '0;
      l_item     = '0;
      m_data     = '0;
      a_v        = 1'b0;
      l_v        = 1'b0;
      a_take     = 1'b0;
      l_take     = 1'b0;
      m_full     = 1'b0;
      m_prev_lsu = 1'b1;
      m_cnt      = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         // Producers retire what was taken and may offer something new;
         // an offered item stays put until it is taken.
         if (a_take) a_v = 1'b0;
         if (l_take) l_v = 1'b0;
         if (!a_v && $urandom_range(1, 0) == 1) begin a_item = mk(5'($urandom), $urandom); a_v = 1'b1; end
         if (!l_v && $urandom_range(1, 0) == 1) begin l_item = mk(5'($urandom), $urandom); l_v = 1'b1; end
         rdy           = ($urandom_range(3, 0) != 0);
         inv           = ($urandom_range(15, 0) == 0);
         alu_if.tvalid = a_v;
         alu_if.tdata  = a_item;
         lsu_if.tvalid = l_v;
         lsu_if.tdata  = l_item;
         wb_if.tready  = rdy;
         invalidate    = inv;
         @(negedge clk);
         open_slot = (!m_full || rdy) && !inv;
         exp_a     = 1'b0;
         exp_l     = 1'b0;
         if (open_slot) begin
            if (a_v && l_v) begin
               exp_a = m_prev_lsu;
               exp_l = !m_prev_lsu;
            end else begin
               exp_a = a_v;
               exp_l = l_v;
            end
         end
         total++;
         if (alu_if.tready !== exp_a) begin bad++; $display("FAIL rnd_alu_tready c%0d: got %b want %b", cyc, alu_if.tready, exp_a); end
         total++;
         if (lsu_if.tready !== exp_l) begin bad++; $display("FAIL rnd_lsu_tready c%0d: got %b want %b", cyc, lsu_if.tready, exp_l); end
         total++;
         if (wb_if.tvalid !== m_full) begin bad++; $display("FAIL rnd_tvalid c%0d: got %b want %b", cyc, wb_if.tvalid, m_full); end
         total++;
         if (instret !== m_cnt) begin bad++; $display("FAIL rnd_instret c%0d: got %0d want %0d", cyc, instret, m_cnt); end
         if (m_full) begin
            total++;
            if (wb_data !== m_data) begin bad++; $display("FAIL rnd_tdata c%0d: got %h want %h", cyc, wb_data, m_data); end
         end
         // What the next cycle should look like.
         if (m_full && rdy) m_cnt = m_cnt + 1'b1;
         if (inv) begin
            m_full = 1'b0;
         end else if (exp_a || exp_l) begin
            m_full     = 1'b1;
            m_data     = wb_of(exp_a ? a_item : l_item);
            m_prev_lsu = exp_l;
         end else if (rdy) begin
            m_full = 1'b0;
         end
         a_take = exp_a;
         l_take = exp_l;
         step();
      end
      alu_if.tvalid = 1'b0;
      lsu_if.tvalid = 1'b0;
      invalidate    = 1'b0;
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst           = 1'b1;
      invalidate    = 1'b0;
      alu_if.tvalid = 1'b0;
      lsu_if.tvalid = 1'b0;
      alu_if.tdata  = '0;
      lsu_if.tdata  = '0;
      wb_if.tready  = 1'b0;
      test_reset();
      test_alu_single();
      test_tie_round_robin();
      test_backpressure();
      test_invalidate();
      test_reset_mid();
      test_instret_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
